ibex_clintx_irq_arbiter: RTL and testbench
==========================================

Name: ibex_clintx_irq_arbiter

Overview:
- Collects up to 32 CLINTx interrupt lines, detects rising edges and latches them as pending (feeds CSR_MIPX).
- Arbitrates enabled pending lines (CSR_MIEX mask, gated by mstatus.MIE) and presents one request to the ID-stage controller.
- Each request carries an EXC_CAUSE_IRQ_X_* cause and a vector derived from CSR_MTVECX.
- Sequences one interrupt at a time through request, acknowledge and completion.

Parameters:
- NumIrqs, 32, number of CLINTx lines, legal range 1..32; IDs 0..NumIrqs-1.
- SyncStages, 2, flop stages on irq_x_i before edge detect; 0 means no synchroniser.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- irq_x_i  in  NumIrqs  raw interrupt lines, rising-edge triggered
- mie_i  in  1  mstatus.MIE global enable
- miex_i  in  NumIrqs  per-line enable from CSR_MIEX
- mtvecx_i  in  32  CSR_MTVECX base
- mipx_clr_i  in  NumIrqs  write-1-to-clear pulses from CSR_MIPX write
- irq_ack_i  in  1  controller accepts current request
- irq_complete_i  in  1  handler finished (mret of CLINTx trap)
- mipx_o  out  NumIrqs  pending register
- irq_req_o  out  1  request to controller
- irq_id_o  out  5  ID of requested or in-service line
- irq_cause_o  out  6  {1'b1, irq_id_o}
- irq_vec_o  out  32  {mtvecx_i[31:7], irq_id_o, 2'b00}
- irq_active_o  out  1  an interrupt is in service

Behaviour:
- Reset: sync flops, edge-history flops, mipx_o, last-grant pointer = 0; FSM = IDLE; irq_req_o = 0, irq_active_o = 0, irq_id_o = 0.
- Edge detect: a pending bit is set when the synchronised line is 1 and its history flop is 0.
- Latency: a rising edge sampled at clock edge E is visible on mipx_o after edge E+SyncStages+1.
- Pending clear: clear on ack of that ID, or on mipx_clr_i[k]. If a new edge and a clear for the same bit occur in the same cycle, set wins (bit stays 1).
- Candidates: cand = mipx_o & miex_i, only when mie_i = 1.
- Default arbitration: fixed priority, lowest ID wins.
- FSM IDLE: if cand != 0, register the winner into irq_id_o and go to REQ. irq_req_o = 1 from the next cycle.
- FSM REQ:
  - irq_req_o = 1; irq_id_o, irq_cause_o and irq_vec_o are held stable.
  - If irq_ack_i: clear pending[id], go to ACTIVE.
  - Else if the winner is no longer a candidate (pending cleared, miex bit dropped, or mie_i = 0): withdraw and go to IDLE; irq_req_o = 0 next cycle.
  - Ack wins over withdraw when both occur in the same cycle.
- FSM ACTIVE: irq_active_o = 1, irq_req_o = 0, irq_id_o held. New edges still latch into pending. On irq_complete_i go to IDLE. There is no nesting.
- Ignored inputs: irq_ack_i outside REQ; irq_complete_i outside ACTIVE.
- Back-to-back: from IDLE entered on complete, re-arbitration happens the same cycle, so the next request appears 1 cycle after leaving ACTIVE.
- Reset mid-operation: immediate return to reset state; pending bits are lost.
- IDs >= NumIrqs never occur. Unused upper bits of 32-wide internal vectors are tied to 0.

Optional Feature:
- Macro: IBEX_CLINTX_RR_EN.
- Defined: round-robin arbitration. Search starts at (last_granted+1) mod NumIrqs and wraps. last_granted updates on irq_ack_i only; a withdrawal does not update it.
- Undefined: fixed priority, lowest ID wins, and the pointer logic is absent.

Test Plan:
- Single line: SyncStages=2, pulse irq_x_i[5] with miex=all-ones, mie=1. Expect mipx_o[5]=1 three edges later, irq_req_o one cycle after that, irq_id_o=5, irq_cause_o=6'h25, irq_vec_o=0x8000_0014 with mtvecx=0x8000_0000. On ack: mipx_o[5]=0, irq_active_o=1.
- Priority: edges on lines 9 and 2 in the same cycle. Expect grant 2; after complete, grant 9 one cycle later. Under IBEX_CLINTX_RR_EN with last_granted=2 and lines 1 and 9 pending, expect grant 9 first.
- Withdraw: line 4 in REQ, then drop miex_i[4] before ack. Expect irq_req_o=0 next cycle, mipx_o[4] still 1. Re-enable: request returns with id 4.
- Set-vs-clear: mipx_clr_i[7] in the same cycle as a new edge on line 7. Expect mipx_o[7]=1. A clear alone gives mipx_o[7]=0.
- Stray handshakes: irq_ack_i in IDLE and irq_complete_i in REQ. Expect no state change and no pending change.
- Async reset: assert rst_i during ACTIVE with 3 pending bits set. Expect all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ibex_clintx_irq_arbiter.sv
// CLINTx interrupt arbiter: latches rising edges of up to 32 lines into MIPX and walks one
// interrupt at a time through request, acknowledge and completion. Optional: IBEX_CLINTX_RR_EN.
module ibex_clintx_irq_arbiter #(
  parameter int NumIrqs    = 32,
  parameter int SyncStages = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumIrqs-1:0] irq_x_i,
  input  logic               mie_i,
  input  logic [NumIrqs-1:0] miex_i,
  input  logic [31:0]        mtvecx_i,
  input  logic [NumIrqs-1:0] mipx_clr_i,
  input  logic               irq_ack_i,
  input  logic               irq_complete_i,
  output logic [NumIrqs-1:0] mipx_o,
  output logic               irq_req_o,
  output logic [4:0]         irq_id_o,
  output logic [5:0]         irq_cause_o,
  output logic [31:0]        irq_vec_o,
  output logic               irq_active_o
);

  typedef enum logic [1:0] {StIdle, StReq, StActive} state_e;

  state_e             state_q;
  logic [NumIrqs-1:0] line_sync;
  logic [NumIrqs-1:0] line_q;
  logic [NumIrqs-1:0] hist_q;
  logic [NumIrqs-1:0] rise;
  logic [NumIrqs-1:0] ack_clr;
  logic [31:0]        cand;
  logic [4:0]         winner;
  logic               ack_take;
  logic [6:0]         unused_mtvecx;

  if (SyncStages == 0) begin : g_nosync
    assign line_sync = irq_x_i;
  end else if (SyncStages == 1) begin : g_sync1
    logic [NumIrqs-1:0] sync_q;
    // NOTE: sequential state is always updated with <=, so every flop sees pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= irq_x_i;
    end
    assign line_sync = sync_q;
  end else begin : g_syncn
    logic [SyncStages-1:0][NumIrqs-1:0] sync_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= {sync_q[SyncStages-2:0], irq_x_i};
    end
    assign line_sync = sync_q[SyncStages-1];
  end

  // The sampled line and its one-cycle history form the edge detector.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q <= '0;
      hist_q <= '0;
    end else begin
      line_q <= line_sync;
      hist_q <= line_q;
    end
  end

  assign rise     = line_q & ~hist_q;
  assign ack_take = (state_q == StReq) && irq_ack_i;

  for (genvar k = 0; k < NumIrqs; k++) begin : g_ack_clr
    assign ack_clr[k] = ack_take && (irq_id_o == 5'(k));
  end

  // Set has priority over any clear in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mipx_o <= '0;
    else       mipx_o <= (mipx_o & ~(mipx_clr_i | ack_clr)) | rise;
  end

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    cand = '0;
    if (mie_i) cand[NumIrqs-1:0] = mipx_o & miex_i;
  end

`ifdef IBEX_CLINTX_RR_EN
  logic [4:0] last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         last_q <= '0;
    else if (ack_take) last_q <= irq_id_o;
  end

  // Rotating search from the line after the last acknowledged one.
  always_comb begin
    int  start;
    int  idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    start  = (int'(last_q) + 1 >= NumIrqs) ? 0 : int'(last_q) + 1;
    for (int i = 0; i < NumIrqs; i++) begin
      idx = start + i;
      if (idx >= NumIrqs) idx = idx - NumIrqs;
      if (!found && cand[idx[4:0]]) begin
        found  = 1'b1;
        winner = idx[4:0];
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NumIrqs - 1; i >= 0; i--) begin
      if (cand[i[4:0]]) winner = i[4:0];
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      irq_req_o    <= 1'b0;
      irq_active_o <= 1'b0;
      irq_id_o     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cand != '0) begin
            irq_id_o  <= winner;
            irq_req_o <= 1'b1;
            state_q   <= StReq;
          end
        end
        StReq: begin
          if (irq_ack_i) begin
            irq_req_o    <= 1'b0;
            irq_active_o <= 1'b1;
            state_q      <= StActive;
          end else if (!cand[irq_id_o]) begin
            irq_req_o <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StActive: begin
          if (irq_complete_i) begin
            irq_active_o <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign irq_cause_o   = {1'b1, irq_id_o};
  assign irq_vec_o     = {mtvecx_i[31:7], irq_id_o, 2'b00};
  assign unused_mtvecx = mtvecx_i[6:0];

endmodule

// File: tb/tb_ibex_clintx_irq_arbiter.sv
// Bench for ibex_clintx_irq_arbiter: directed scenarios plus randomized traffic against a
// behavioural model built from sample history, a pending word and a three-phase handshake.
module tb_ibex_clintx_irq_arbiter;
  localparam int N = 32;
  localparam int S = 2;
  localparam int M_IDLE = 0, M_REQ = 1, M_ACT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_x;
  logic         mie;
  logic [N-1:0] miex;
  logic [31:0]  mtvecx;
  logic [N-1:0] mipx_clr;
  logic         ack;
  logic         complete;
  logic [N-1:0] mipx;
  logic         irq_req;
  logic [4:0]   irq_id;
  logic [5:0]   irq_cause;
  logic [31:0]  irq_vec;
  logic         irq_active;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [N-1:0] samp_q[$];
  logic [31:0]  m_pend;
  int           m_state;
  logic [4:0]   m_id;
  logic [4:0]   m_last;

  ibex_clintx_irq_arbiter #(.NumIrqs(N), .SyncStages(S)) dut (
    .clk_i(clk), .rst_i(rst), .irq_x_i(irq_x), .mie_i(mie), .miex_i(miex),
    .mtvecx_i(mtvecx), .mipx_clr_i(mipx_clr), .irq_ack_i(ack), .irq_complete_i(complete),
    .mipx_o(mipx), .irq_req_o(irq_req), .irq_id_o(irq_id), .irq_cause_o(irq_cause),
    .irq_vec_o(irq_vec), .irq_active_o(irq_active)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] lowest_id(input logic [31:0] v);
    logic [31:0] one;
    one = v & (~v + 32'd1);
    return 5'($clog2(one));
  endfunction

  function automatic logic [4:0] pick(input logic [31:0] c, input logic [4:0] last);
`ifdef IBEX_CLINTX_RR_EN
    int          start;
    logic [63:0] dbl;
    start = (int'(last) + 1) % N;
    dbl   = {c, c} >> start;
    return 5'((int'(lowest_id(dbl[31:0])) + start) % N);
`else
    if (last > 5'd31) return 5'd0;
    return lowest_id(c);
`endif
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_state = M_IDLE;
    m_id    = '0;
    m_last  = '0;
    samp_q.delete();
    repeat (S + 3) samp_q.push_front('0);
  endtask

  // One clock: the model consumes the inputs seen at the rising edge; return at the falling edge.
  task automatic cycle();
    logic [31:0] cnd, clr, rse;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      samp_q.push_front(irq_x);
      samp_q.delete(samp_q.size() - 1);
      rse = samp_q[S+1] & ~samp_q[S+2];
      cnd = mie ? (m_pend & miex) : 32'd0;
      clr = mipx_clr;
      case (m_state)
        M_IDLE: if (cnd != 0) begin m_id = pick(cnd, m_last); m_state = M_REQ; end
        M_REQ: begin
          if (ack) begin clr = clr | (32'd1 << m_id); m_last = m_id; m_state = M_ACT; end
          else if (!cnd[m_id]) m_state = M_IDLE;
        end
        M_ACT: if (complete) m_state = M_IDLE;
        default: m_state = M_IDLE;
      endcase
      m_pend = (m_pend & ~clr) | rse;
    end
    @(negedge clk);
  endtask

  task automatic pulse_mask(input logic [N-1:0] m);
    irq_x = m;
    cycle();
    irq_x = '0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (irq_req === 1'b1) begin ok = 1'b1; break; end
      cycle();
    end
  endtask

  task automatic ack_then_complete();
    ack = 1'b1; cycle(); ack = 1'b0;
    complete = 1'b1; cycle(); complete = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cycle();
    n_total++; if (mipx !== '0) $display("FAIL reset_mipx: got %h want 0", mipx); else n_pass++;
    n_total++; if (irq_req !== 1'b0) $display("FAIL reset_req: got %b want 0", irq_req); else n_pass++;
    n_total++; if (irq_active !== 1'b0) $display("FAIL reset_active: got %b want 0", irq_active); else n_pass++;
    n_total++; if (irq_id !== 5'd0) $display("FAIL reset_id: got %0d want 0", irq_id); else n_pass++;
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_single_line();
    pulse_mask(N'(1) << 5);
    cycle(); cycle();
    n_total++; if (mipx[5] !== 1'b0) $display("FAIL single_early: mipx[5] got %b want 0", mipx[5]); else n_pass++;
    cycle();
    n_total++; if (mipx[5] !== 1'b1) $display("FAIL single_latency: mipx[5] got %b want 1", mipx[5]); else n_pass++;
    n_total++; if (irq_req !== 1'b0) $display("FAIL single_req_early: got %b want 0", irq_req); else n_pass++;
    cycle();
    n_total++; if (irq_req !== 1'b1) $display("FAIL single_req: got %b want 1", irq_req); else n_pass++;
    n_total++; if (irq_id !== 5'd5) $display("FAIL single_id: got %0d want 5", irq_id); else n_pass++;
    n_total++; if (irq_cause !== 6'h25) $display("FAIL single_cause: got %h want 25", irq_cause); else n_pass++;
    n_total++; if (irq_vec !== 32'h8000_0014) $display("FAIL single_vec: got %h want 80000014", irq_vec); else n_pass++;
    ack = 1'b1; cycle(); ack = 1'b0;
    n_total++; if (mipx[5] !== 1'b0) $display("FAIL single_ack_clr: mipx[5] got %b want 0", mipx[5]); else n_pass++;
    n_total++; if (irq_active !== 1'b1 || irq_req !== 1'b0)
      $display("FAIL single_active: active/req got %b%b want 10", irq_active, irq_req); else n_pass++;
    complete = 1'b1; cycle(); complete = 1'b0;
    n_total++; if (irq_active !== 1'b0) $display("FAIL single_complete: active got %b want 0", irq_active); else n_pass++;
  endtask

  task automatic test_priority();
    bit ok;
    pulse_mask((N'(1) << 9) | (N'(1) << 2));
    wait_req(ok);
    n_total++; if (!ok || irq_id !== 5'd2) $display("FAIL prio_first: req %b id %0d want req 1 id 2", ok, irq_id); else n_pass++;
    ack = 1'b1; cycle(); ack = 1'b0;
`ifdef IBEX_CLINTX_RR_EN
    pulse_mask(N'(1) << 1);
    repeat (3) cycle();
`endif
    complete = 1'b1; cycle(); complete = 1'b0;
    n_total++; if (irq_req !== 1'b0 || irq_active !== 1'b0)
      $display("FAIL prio_gap: req/active got %b%b want 00", irq_req, irq_active); else n_pass++;
    cycle();
    n_total++; if (irq_req !== 1'b1 || irq_id !== 5'd9)
      $display("FAIL prio_second: req %b id %0d want req 1 id 9", irq_req, irq_id); else n_pass++;
    ack_then_complete();
`ifdef IBEX_CLINTX_RR_EN
    wait_req(ok);
    n_total++; if (!ok || irq_id !== 5'd1) $display("FAIL prio_rr_wrap: req %b id %0d want req 1 id 1", ok, irq_id); else n_pass++;
    ack_then_complete();
`endif
  endtask

  task automatic test_withdraw();
    bit ok;
    pulse_mask(N'(1) << 4);
    wait_req(ok);
    n_total++; if (!ok || irq_id !== 5'd4) $display("FAIL withdraw_req: req %b id %0d want req 1 id 4", ok, irq_id); else n_pass++;
    miex = ~(N'(1) << 4);
    cycle();
    n_total++; if (irq_req !== 1'b0) $display("FAIL withdraw_drop: req got %b want 0", irq_req); else n_pass++;
    n_total++; if (mipx[4] !== 1'b1) $display("FAIL withdraw_keep: mipx[4] got %b want 1", mipx[4]); else n_pass++;
    cycle();
    n_total++; if (irq_req !== 1'b0) $display("FAIL withdraw_idle: req got %b want 0", irq_req); else n_pass++;
    miex = '1;
    cycle();
    n_total++; if (irq_req !== 1'b1 || irq_id !== 5'd4)
      $display("FAIL withdraw_return: req %b id %0d want req 1 id 4", irq_req, irq_id); else n_pass++;
    ack_then_complete();
  endtask

  task automatic test_set_clear();
    mie = 1'b0;
    pulse_mask(N'(1) << 7);
    cycle(); cycle();
    mipx_clr = N'(1) << 7;
    cycle();
    mipx_clr = '0;
    n_total++; if (mipx[7] !== 1'b1) $display("FAIL setclr_set_wins: mipx[7] got %b want 1", mipx[7]); else n_pass++;
    mipx_clr = N'(1) << 7;
    cycle();
    mipx_clr = '0;
    n_total++; if (mipx[7] !== 1'b0) $display("FAIL setclr_clear: mipx[7] got %b want 0", mipx[7]); else n_pass++;
    mie = 1'b1;
  endtask

  task automatic test_stray();
    mie = 1'b0;
    pulse_mask(N'(1) << 3);
    repeat (3) cycle();
    ack = 1'b1; cycle(); ack = 1'b0;
    n_total++; if (irq_req !== 1'b0 || irq_active !== 1'b0 || mipx !== (N'(1) << 3))
      $display("FAIL stray_ack: req %b active %b mipx %h want 0 0 00000008", irq_req, irq_active, mipx); else n_pass++;
    mie = 1'b1;
    cycle();
    complete = 1'b1; cycle(); complete = 1'b0;
    n_total++; if (irq_req !== 1'b1 || irq_active !== 1'b0 || irq_id !== 5'd3 || mipx !== (N'(1) << 3))
      $display("FAIL stray_complete: req %b active %b id %0d mipx %h want 1 0 3 00000008",
               irq_req, irq_active, irq_id, mipx); else n_pass++;
    ack_then_complete();
  endtask

  task automatic test_async_reset();
    bit ok;
    pulse_mask(N'(1) << 10);
    wait_req(ok);
    ack = 1'b1; cycle(); ack = 1'b0;
    pulse_mask(N'(7) << 11);
    repeat (3) cycle();
    n_total++; if (irq_active !== 1'b1 || mipx !== 32'h0000_3800)
      $display("FAIL areset_setup: active %b mipx %h want 1 00003800", irq_active, mipx); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (mipx !== '0 || irq_req !== 1'b0 || irq_active !== 1'b0 || irq_id !== 5'd0)
      $display("FAIL areset_immediate: mipx %h req %b active %b id %0d want all 0",
               mipx, irq_req, irq_active, irq_id); else n_pass++;
    model_reset();
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    logic [83:0] got, exp;
    for (int t = 0; t < 600; t++) begin
      irq_x    = $urandom & $urandom & $urandom;
      miex     = ($urandom_range(0, 5) == 0) ? $urandom : '1;
      mie      = ($urandom_range(0, 9) != 0);
      mipx_clr = ($urandom_range(0, 5) == 0) ? ($urandom & $urandom) : '0;
      ack      = (m_state == M_REQ) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      complete = ($urandom_range(0, 3) == 0);
      cycle();
      got = {mipx, irq_req, irq_active, irq_id, irq_cause, irq_vec};
      exp = {m_pend, m_state == M_REQ, m_state == M_ACT, m_id, {1'b1, m_id},
             {mtvecx[31:7], m_id, 2'b00}};
      n_total++;
      if (got !== exp) $display("FAIL rand_t%0d: {mipx,req,act,id,cause,vec} got %h want %h", t, got, exp);
      else n_pass++;
    end
    irq_x = '0; mipx_clr = '0; ack = 1'b0; complete = 1'b0; miex = '1; mie = 1'b1;
  endtask

  initial begin
    rst = 1'b1; irq_x = '0; mie = 1'b1; miex = '1; mtvecx = 32'h8000_0000;
    mipx_clr = '0; ack = 1'b0; complete = 1'b0;
    model_reset();
    test_reset();
    test_single_line();
    test_priority();
    test_withdraw();
    test_set_clear();
    test_stray();
    test_async_reset();
    mtvecx = $urandom;
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
